// File: rtl/neopixel_pkg.sv
// Shared NeoPixel definitions: receiver state encoding, nominal transmit timings
// and the default pixel word width.
package neopixel_pkg;

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} rx_state_t;

  // Nominal transmitter timings in 50 MHz cycles, shared with the transmitter
  localparam int T1H_CYC    = 35;
  localparam int T1L_CYC    = 30;
  localparam int T0H_CYC    = 18;
  localparam int T0L_CYC    = 40;
  localparam int TLATCH_CYC = 2500;

  localparam int WORD_BITS_DEF = 24;

endpackage

// File: rtl/neopixel_rx_if.sv
// NeoPixel receiver signal bundle: serial line in/out plus decoded word/frame events.
// master = receiver side, slave = consumer/driver side.
interface neopixel_rx_if #(
  parameter int WORD_BITS = 24
);
  logic                 neopixel_in;
  logic                 neopixel_out;
  logic [WORD_BITS-1:0] data;
  logic                 valid;
  logic                 frame_done;
  logic [7:0]           frame_words;
  logic                 error;

  modport master (
    input  neopixel_in,
    output neopixel_out, data, valid, frame_done, frame_words, error
  );

  modport slave (
    output neopixel_in,
    input  neopixel_out, data, valid, frame_done, frame_words, error
  );
endinterface

// File: rtl/neopixel_pulse_meter.sv
// Synchronizes the serial line, detects edges and measures how long the
// synchronized level has been stable with a saturating counter.
module neopixel_pulse_meter #(
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             line_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic             level_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [1:0]       sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~prev_q;
  assign fall_o  = ~sync_q[1] & prev_q;
  assign cnt_o   = cnt_q;

  // Count is 1 on the first cycle after an edge, so the edge cycle sees the full width
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      prev_q <= sync_q[1];
      if (rise_o || fall_o)   cnt_q <= CNT_W'(1);
      else if (cnt_q != '1)   cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/neopixel_rx.sv
// WS2812-style single-wire receiver: decodes pulse widths into GRB words, MSB first.
// Optional pass-through of words after the first is enabled by NEOPIXEL_RX_PASSTHRU_EN.
module neopixel_rx
  import neopixel_pkg::*;
#(
  parameter int CNT_W        = 12,
  parameter int T1_THRESH    = 27,
  parameter int HIGH_MIN     = 8,
  parameter int HIGH_MAX     = 60,
  parameter int LATCH_CYCLES = 2000,
  parameter int WORD_BITS    = WORD_BITS_DEF
) (
  input  logic          clock,
  input  logic          reset,
  neopixel_rx_if.master rx
);
  localparam int BC_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] T1_C    = CNT_W'(T1_THRESH);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] LATCH_C = CNT_W'(LATCH_CYCLES);
  localparam logic [BC_W-1:0]  WB_C    = BC_W'(WORD_BITS);

  logic             rise, fall, level;
  logic [CNT_W-1:0] cnt;

  neopixel_pulse_meter #(.CNT_W(CNT_W)) u_meter (
    .clock   (clock),
    .reset   (reset),
    .line_i  (rx.neopixel_in),
    .rise_o  (rise),
    .fall_o  (fall),
    .level_o (level),
    .cnt_o   (cnt)
  );

  rx_state_t            state_q, state_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]           word_cnt_q, word_cnt_d, frame_words_q, frame_words_d;
  logic                 valid_q, valid_d, done_q, done_d, err_q, err_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= SYNC;
      shreg_q       <= '0;
      data_q        <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      frame_words_q <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      frame_words_q <= frame_words_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    data_d        = data_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    frame_words_d = frame_words_q;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;

    // Word completion is retired one cycle after the last bit is shifted in
    if (bit_cnt_q == WB_C) begin
      data_d    = shreg_q;
      valid_d   = 1'b1;
      bit_cnt_d = '0;
      if (word_cnt_q != 8'hFF) word_cnt_d = word_cnt_q + 8'd1;
    end

    unique case (state_q)
      SYNC: if (!level && cnt >= LATCH_C) state_d = IDLE;
      IDLE: begin
        if (rise) begin
          state_d    = HIGH;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      HIGH: begin
        if (fall) begin
          if (cnt < MIN_C) begin
            err_d   = 1'b1;
            state_d = SYNC;
          end else begin
            shreg_d   = {shreg_q[WORD_BITS-2:0], (cnt >= T1_C)};
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            state_d   = LOW;
          end
        end else if (cnt > MAX_C) begin
          err_d   = 1'b1;
          state_d = SYNC;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (!level && cnt >= LATCH_C) begin
          done_d        = 1'b1;
          frame_words_d = word_cnt_q;
          err_d         = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
          state_d       = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign rx.data        = data_q;
  assign rx.valid       = valid_q;
  assign rx.frame_done  = done_q;
  assign rx.frame_words = frame_words_q;
  assign rx.error       = err_q;

`ifdef NEOPIXEL_RX_PASSTHRU_EN
  // Forward the line once this pixel has consumed its own word
  logic gate_q, pt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gate_q <= 1'b0;
      pt_q   <= 1'b0;
    end else begin
      pt_q <= level & gate_q;
      if (done_d || err_d || state_d == SYNC) gate_q <= 1'b0;
      else if (valid_d)                       gate_q <= 1'b1;
    end
  end

  assign rx.neopixel_out = pt_q;
`else
  assign rx.neopixel_out = 1'b0;
`endif
endmodule

// File: tb/tb_neopixel_rx.sv
// Randomized scoreboard bench for neopixel_rx: a pulse-level reference model queues
// expected word/frame/error events, a negedge monitor pops and compares them.
module tb_neopixel_rx;
  import neopixel_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  neopixel_rx_if #(.WORD_BITS(24)) rx();

  neopixel_rx dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx)
  );

  always #10 clock = ~clock;

  typedef enum int {EV_VALID, EV_FRAME, EV_ERR} ev_k_t;
  typedef struct {
    ev_k_t       k;
    logic [23:0] d;
    int          w;
    bit          e;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0, n_fail = 0;
  int  cyc = 0, last_fall_cyc = 0, last_valid_cyc = 0;

  // Reference model: 0 = hunting for gap, 1 = idle between frames, 2 = inside a frame
  int          m_st = 0;
  int          m_bits = 0, m_words = 0;
  logic [23:0] m_word = '0, m_data = '0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input ev_k_t k, input logic [23:0] d, input int w, input bit e);
    ev_t ev;
    ev.k = k; ev.d = d; ev.w = w; ev.e = e;
    exp_q.push_back(ev);
  endtask

  task automatic low(input int l);
    if (l > 2000) begin
      if (m_st == 2) push(EV_FRAME, '0, m_words, m_bits != 0);
      m_st = 1; m_bits = 0; m_words = 0;
    end
    rx.neopixel_in = 1'b0;
    repeat (l) @(negedge clock);
  endtask

  task automatic pulse(input int h, input int l);
    if (m_st != 0) begin
      if (h < 8 || h > 60) begin
        push(EV_ERR, '0, 0, 1'b0);
        m_st = 0;
      end else begin
        m_st   = 2;
        m_word = (m_word << 1) | ((h >= 27) ? 24'd1 : 24'd0);
        m_bits++;
        if (m_bits == 24) begin
          m_data = m_word;
          push(EV_VALID, m_word, 0, 1'b0);
          m_bits = 0;
          if (m_words < 255) m_words++;
        end
      end
    end
    rx.neopixel_in = 1'b1;
    repeat (h) @(negedge clock);
    rx.neopixel_in = 1'b0;
    last_fall_cyc = cyc;
    low(l);
  endtask

  task automatic send_word(input logic [23:0] w, input bit tx);
    for (int i = 23; i >= 0; i--) begin
      if (tx) pulse(w[i] ? T1H_CYC : T0H_CYC, w[i] ? T1L_CYC : T0L_CYC);
      else    pulse(w[i] ? int'($urandom_range(27, 60)) : int'($urandom_range(8, 26)),
                    int'($urandom_range(5, 60)));
    end
  endtask

  task automatic rand_bits(input int n);
    for (int i = 0; i < n; i++) pulse(int'($urandom_range(8, 60)), int'($urandom_range(5, 60)));
  endtask

`ifdef NEOPIXEL_RX_PASSTHRU_EN
  logic [2:0] hist = '0;
  bit         pt_chk = 1'b0, pt_win = 1'b0;
  always @(posedge clock) hist <= {hist[1:0], rx.neopixel_in};
`endif

  // Monitor: every DUT event must match the head of the expectation queue
  always @(negedge clock) begin
    ev_t e;
    if (!reset && (rx.valid || rx.frame_done || rx.error)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: valid=%0b frame_done=%0b error=%0b, nothing expected (cycle %0d)",
                 rx.valid, rx.frame_done, rx.error, cyc);
      end else begin
        e = exp_q.pop_front();
        if (rx.valid) begin
          last_valid_cyc = cyc;
          check("event_is_valid", rx.valid && !rx.frame_done, e.k == EV_VALID);
          check("data", rx.data, e.d);
`ifndef NEOPIXEL_RX_PASSTHRU_EN
          check("out_tied_low", rx.neopixel_out, 1'b0);
`endif
        end else if (rx.frame_done) begin
          check("event_is_frame", rx.frame_done, e.k == EV_FRAME);
          check("frame_words", rx.frame_words, e.w);
          check("frame_error", rx.error, e.e);
        end else begin
          check("event_is_error", rx.error, e.k == EV_ERR);
        end
      end
    end
`ifdef NEOPIXEL_RX_PASSTHRU_EN
    if (pt_chk && !reset) check("passthru", rx.neopixel_out, pt_win ? hist[2] : 1'b0);
`endif
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},        rx.data,         24'h0);
    check({tag, "_valid"},       rx.valid,        1'b0);
    check({tag, "_frame_done"},  rx.frame_done,   1'b0);
    check({tag, "_frame_words"}, rx.frame_words,  8'h0);
    check({tag, "_error"},       rx.error,        1'b0);
    check({tag, "_out"},         rx.neopixel_out, 1'b0);
  endtask

  initial begin
    #(20 * 140000);
    $display("FAIL watchdog: simulation did not finish within cycle budget (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f24;
    rx.neopixel_in = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    low(TLATCH_CYC);
    send_word(24'hA53C0F, 1'b1);
    f24 = last_fall_cyc;
    low(TLATCH_CYC);
    check("valid_latency", last_valid_cyc - f24, 4);

    send_word(24'h000000, 1'b1);
    send_word(24'hFFFFFF, 1'b1);
    low(TLATCH_CYC);

    // Partial word at the latch
    rand_bits(10);
    low(TLATCH_CYC);
    check("data_kept_after_partial", rx.data, m_data);

    // Over-long high mid-word, trailing bits ignored until a gap
    rand_bits(5);
    pulse(70, 30);
    rand_bits(4);
    low(TLATCH_CYC);
    send_word(24'h123456, 1'b0);
    low(TLATCH_CYC);

    // Short glitch mid-word
    rand_bits(7);
    pulse(3, 30);
    rand_bits(3);
    low(TLATCH_CYC);
    send_word(24'hC0FFEE, 1'b0);
    low(TLATCH_CYC);

    // Threshold and width limits: 26/8 decode 0, 27/60 decode 1
    for (int i = 0; i < 6; i++) begin
      pulse(26, 20); pulse(27, 20); pulse(8, 20); pulse(60, 20);
    end
    low(TLATCH_CYC);
    check("threshold_word", rx.data, 24'h555555);

    // Two-word frame: second word should appear on the pass-through line
`ifdef NEOPIXEL_RX_PASSTHRU_EN
    pt_chk = 1'b1;
`endif
    send_word(24'h3C3C3C, 1'b1);
`ifdef NEOPIXEL_RX_PASSTHRU_EN
    pt_win = 1'b1;
`endif
    send_word(24'h81F00D, 1'b1);
    low(TLATCH_CYC);
`ifdef NEOPIXEL_RX_PASSTHRU_EN
    pt_win = 1'b0;
    pt_chk = 1'b0;
`endif

    // Reset during bit 12
    rand_bits(11);
    check("no_pending_before_reset", exp_q.size(), 0);
    rx.neopixel_in = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_outputs("midword_reset");
    m_st = 0; m_bits = 0; m_words = 0; m_data = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    low(TLATCH_CYC);
    send_word(24'h0F1E2D, 1'b1);
    low(TLATCH_CYC);

    for (int f = 0; f < 5; f++) begin
      int nw;
      nw = int'($urandom_range(1, 2));
      for (int w = 0; w < nw; w++) send_word(24'($urandom), 1'b0);
      low(2100);
    end

    repeat (10) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
